// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types for the pipeline hazard controller.
//   - sb_entry_t   : one in-flight writer {valid, wb, dest, load}
//   - fwd_sel_e    : bypass select encoding (regfile / EXE / MEM / WB)
//   - ctrl_state_e : sequencer states (RUN / DRAIN / HALTED)
//   - REG_W_DEF    : default register-index width; the scoreboard entry
//                    stores dest at this width, so REG_W must not exceed it
//   - youngest_hit : priority pick of the youngest matching stage
//   Optional feature macro used by the importers: PIPE_FWD_EN
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int REG_W_DEF = 5;
   localparam int SB_DEPTH  = 3;   // EXE, MEM, WB

   typedef struct packed {
      logic                 valid;
      logic                 wb;
      logic [REG_W_DEF-1:0] dest;
      logic                 load;
   } sb_entry_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXE = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } ctrl_state_e;

   // hit[0]=EXE, hit[1]=MEM, hit[2]=WB; the youngest producer holds the
   // most recent value, so EXE beats MEM beats WB.
   function automatic fwd_sel_e youngest_hit(input logic [SB_DEPTH-1:0] hit);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (hit[0])
         sel = FWD_EXE;
      else if (hit[1])
         sel = FWD_MEM;
      else if (hit[2])
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
//   Three-entry shift register of in-flight writers (index 0=EXE, 1=MEM,
//   2=WB) plus per-source RAW match and youngest-stage priority.
//   Macro PIPE_FWD_EN: when defined, only a load sitting in EXE is a hazard
//   and the bypass selects are driven; otherwise any match is a hazard and
//   the bypass selects stay at FWD_RF.
// Ports
//   clk, rst             clock, synchronous active-low reset
//   issue                ID instruction moves into EXE this cycle
//   id_dest/wb_en/mem_r_en  fields captured into the EXE entry on issue
//   id_src1/src2/use_src2   decode sources to check
//   hazard               RAW hazard on a decode source (combinational)
//   sb_empty             no valid entry in EXE, MEM or WB
//   fwd_sel1/fwd_sel2    bypass selects for src1/src2
// -----------------------------------------------------------------------------
module pipe_scoreboard
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src2,
   output logic             hazard,
   output logic             sb_empty,
   output fwd_sel_e         fwd_sel1,
   output fwd_sel_e         fwd_sel2
);

   sb_entry_t            sb_reg [SB_DEPTH];
   sb_entry_t            issue_entry;
   logic [SB_DEPTH-1:0]  valid_vec;
   logic [SB_DEPTH-1:0]  hit1;
   logic [SB_DEPTH-1:0]  hit2;
   logic [REG_W_DEF-1:0] src1_w;
   logic [REG_W_DEF-1:0] src2_w;

   assign src1_w = REG_W_DEF'(id_src1);
   assign src2_w = REG_W_DEF'(id_src2);

   // A non-issuing cycle pushes an all-zero (invalid) entry into EXE.
   always_comb begin
      issue_entry = '0;
      if (issue) begin
         issue_entry.valid = 1'b1;
         issue_entry.wb    = id_wb_en;
         issue_entry.dest  = REG_W_DEF'(id_dest);
         issue_entry.load  = id_mem_r_en;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SB_DEPTH; i++)
            sb_reg[i] <= '0;
      end else begin
         sb_reg[0] <= issue_entry;
         for (int i = 1; i < SB_DEPTH; i++)
            sb_reg[i] <= sb_reg[i-1];
      end
   end

   // r0 is hardwired zero, so a writer of r0 never creates a dependency.
   genvar gi;
   generate
      for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
         assign valid_vec[gi] = sb_reg[gi].valid;
         assign hit1[gi] = sb_reg[gi].valid & sb_reg[gi].wb &
                           (sb_reg[gi].dest == src1_w) & (src1_w != '0);
         assign hit2[gi] = sb_reg[gi].valid & sb_reg[gi].wb & id_use_src2 &
                           (sb_reg[gi].dest == src2_w) & (src2_w != '0);
      end
   endgenerate

   assign sb_empty = ~|valid_vec;

`ifdef PIPE_FWD_EN
   // ALU results bypass from any stage; a load's data is not ready until
   // MEM, so only a load in EXE forces a single stall cycle.
   assign hazard   = sb_reg[0].load & (hit1[0] | hit2[0]);
   assign fwd_sel1 = youngest_hit(hit1);
   assign fwd_sel2 = youngest_hit(hit2);
`else
   // No bypass network: hold decode until the writer has left WB.
   assign hazard   = (|hit1) | (|hit2);
   assign fwd_sel1 = FWD_RF;
   assign fwd_sel2 = FWD_RF;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencer beside decode: RAW hazard stall, branch flush,
//   halt/drain sequencing and stall/flush counters.
//   Macro PIPE_FWD_EN selects the bypass build (load-use stall only).
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   id_valid, id_src1, id_src2,
//   id_use_src2, id_dest, id_wb_en,
//   id_mem_r_en                    decode-stage instruction fields
//   br_taken                       branch resolved taken in decode
//   halt_req                       level request to drain and stop issue
//   freeze / id_bubble             hold IF+ID / insert NOP into ID/EXE
//   if_flush                       squash IF/ID
//   fwd_sel1 / fwd_sel2            bypass selects (0 RF,1 EXE,2 MEM,3 WB)
//   halted                         pipeline empty and stopped
//   stall_cnt / flush_cnt          wrapping event counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_use_src2,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic             br_taken,
   input  logic             halt_req,
   output logic             freeze,
   output logic             id_bubble,
   output logic             if_flush,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ctrl_state_e      state_reg;
   ctrl_state_e      state_next;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   logic     hazard;
   logic     sb_empty;
   logic     run_now;
   logic     freeze_int;
   logic     issue;
   logic     flush_int;
   fwd_sel_e sel1;
   fwd_sel_e sel2;

   pipe_scoreboard #(
      .REG_W (REG_W)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .issue       (issue),
      .id_dest     (id_dest),
      .id_wb_en    (id_wb_en),
      .id_mem_r_en (id_mem_r_en),
      .id_src1     (id_src1),
      .id_src2     (id_src2),
      .id_use_src2 (id_use_src2),
      .hazard      (hazard),
      .sb_empty    (sb_empty),
      .fwd_sel1    (sel1),
      .fwd_sel2    (sel2)
   );

   // halt_req stops issue in the very cycle it rises, so the instruction
   // in ID (including a taken branch) stays put instead of escaping into
   // EXE one cycle before the sequencer reaches DRAIN.
   assign run_now    = (state_reg == RUN) & ~halt_req;
   assign freeze_int = hazard | ~run_now;
   assign issue      = id_valid & ~freeze_int;
   // A frozen branch is not honoured; it re-resolves once ID is released.
   assign flush_int  = br_taken & id_valid & ~freeze_int;

   assign freeze    = freeze_int;
   assign id_bubble = freeze_int;
   assign if_flush  = flush_int;
   assign fwd_sel1  = sel1;
   assign fwd_sel2  = sel2;
   assign halted    = (state_reg == HALTED);
   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN: begin
            if (halt_req)
               state_next = DRAIN;
         end
         DRAIN: begin
            if (!halt_req)
               state_next = RUN;
            else if (sb_empty)
               state_next = HALTED;
         end
         HALTED: begin
            if (!halt_req)
               state_next = RUN;
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= RUN;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         // Counters wrap naturally from all-ones back to zero.
         if (hazard & id_valid & (state_reg == RUN))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (flush_int)
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

endmodule
